alu_control_seq: RTL and testbench

Parametrised, registered successor to the combinational ALU control decoder. Decodes `rtype`/`beq`/`func` from the decode stage into an ALU operation code. It registers that code into the execute stage and tracks multi-cycle multiply and divide operations with a countdown and ready/busy handshake, so the pipeline front end stalls until the long operation completes. It sits between instruction decode and the ALU/EX stage.

---
 rtl/alu_control_seq.sv | 149 ++++++++++++++
 tb/tb_alu_control_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq
// Registered ALU control decoder with multi-cycle multiply/divide tracking.
// It decodes rtype/beq/func into an ALU op code and registers it into the
// execute stage. Multiply and divide hold the block BUSY for their latency,
// so the front end stalls on in_ready until the long operation completes.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - decode stage presents an instruction
//   rtype     - instruction is R-type
//   beq       - instruction is branch-equal
//   func      - R-type function field (FUNC_W bits)
//   flush     - synchronous pipeline flush, aborts any in-flight operation
//   in_ready  - block can accept (state is IDLE), from state register only
//   out_op    - registered ALU op code (OP_W bits)
//   out_valid - out_op is a completed/issuable result this cycle
//   out_multi - current/last accepted op is multi-cycle
//   busy      - multi-cycle operation in progress (state is BUSY)
module alu_control_seq #(
  parameter int unsigned       FUNC_W   = 4,
  parameter int unsigned       OP_W     = 4,
  parameter logic [OP_W-1:0]   BEQ_OP   = OP_W'(4'b0010),
  parameter logic [OP_W-1:0]   ADD_OP   = OP_W'(4'b0011),
  parameter logic [FUNC_W-1:0] MUL_FUNC = FUNC_W'(4'b1000),
  parameter logic [FUNC_W-1:0] DIV_FUNC = FUNC_W'(4'b1001),
  parameter int unsigned       MUL_LAT  = 4,
  parameter int unsigned       DIV_LAT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              rtype,
  input  logic              beq,
  input  logic [FUNC_W-1:0] func,
  input  logic              flush,
  output logic              in_ready,
  output logic [OP_W-1:0]   out_op,
  output logic              out_valid,
  output logic              out_multi,
  output logic              busy
);

  // Counter only ever holds L-2, so clog2 of the larger latency is enough.
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_d;
  logic               valid_d;
  logic               multi_d;

  logic [OP_W-1:0]    func_op;
  logic [OP_W-1:0]    dec_op;
  logic               is_multi;
  logic [CNT_W-1:0]   lat_m2;
  logic               accept;

  // func mapped onto the op width: zero-extend or keep the low bits.
  if (FUNC_W >= OP_W) begin : g_func_trunc
    assign func_op = func[OP_W-1:0];
  end else begin : g_func_ext
    assign func_op = {{(OP_W-FUNC_W){1'b0}}, func};
  end

  // Decode; branch-compare takes priority over the func field.
  always_comb begin
    dec_op = ADD_OP;
    if (rtype && beq) begin
      dec_op = BEQ_OP;
    end else if (rtype) begin
      dec_op = func_op;
    end
  end

  // Multi-cycle detection and the initial countdown value (L-2).
  assign is_multi = rtype && !beq && ((func == MUL_FUNC) || (func == DIV_FUNC));
  assign lat_m2   = (func == DIV_FUNC) ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == BUSY);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = out_op;
    valid_d = 1'b0;
    multi_d = out_multi;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      multi_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_d = dec_op;
            if (is_multi) begin
              multi_d = 1'b1;
              cnt_d   = lat_m2;
              state_d = BUSY;
            end else begin
              multi_d = 1'b0;
              valid_d = 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_op    <= '0;
      out_valid <= 1'b0;
      out_multi <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_op    <= op_d;
      out_valid <= valid_d;
      out_multi <= multi_d;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed vectors, expected results queued at
// issue time and matched by a monitor whenever out_valid is presented.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       rtype;
  logic       beq;
  logic [3:0] func;
  logic       flush;
  logic       in_ready;
  logic [3:0] out_op;
  logic       out_valid;
  logic       out_multi;
  logic       busy;

  // Second instance with a wider func field.
  logic       in_valid2;
  logic [5:0] func2;
  logic       in_ready2;
  logic [3:0] out_op2;
  logic       out_valid2;
  logic       out_multi2;
  logic       busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] op;
    logic       multi;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  alu_control_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .rtype    (rtype),
    .beq      (beq),
    .func     (func),
    .flush    (flush),
    .in_ready (in_ready),
    .out_op   (out_op),
    .out_valid(out_valid),
    .out_multi(out_multi),
    .busy     (busy)
  );

  alu_control_seq #(.FUNC_W(6), .OP_W(4)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .rtype    (1'b1),
    .beq      (1'b0),
    .func     (func2),
    .flush    (1'b0),
    .in_ready (in_ready2),
    .out_op   (out_op2),
    .out_valid(out_valid2),
    .out_multi(out_multi2),
    .busy     (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one edge; optionally queue its expected result.
  task automatic issue(input logic r, input logic b, input logic [3:0] f,
                       input logic expect_out, input logic [3:0] eop,
                       input logic emulti, input int lat);
    exp_t e;
    in_valid = 1'b1;
    rtype    = r;
    beq      = b;
    func     = f;
    if (expect_out) begin
      e.op    = eop;
      e.multi = emulti;
      e.cyc   = cyc + lat;
      sbq.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: match every presented result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missed_valid: got none expected op %0h at cycle %0d", e.op, e.cyc);
    end
    if (rst_n === 1'b1 && out_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out_valid=%b op=%0h expected no result (cycle %0d)",
                 out_valid, out_op, cyc);
      end else begin
        e = sbq.pop_front();
        chk("sb_cycle", 32'(cyc), 32'(e.cyc));
        chk("sb_op", 32'(out_op), 32'(e.op));
        chk("sb_multi", 32'(out_multi), 32'(e.multi));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rtype     = 1'b0;
    beq       = 1'b0;
    func      = 4'h0;
    flush     = 1'b0;
    in_valid2 = 1'b0;
    func2     = 6'h0;
    step();
    step();

    // Reset values
    chk("rst_op", 32'(out_op), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_multi", 32'(out_multi), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    step();

    // Non-R-type: address add, one-cycle valid pulse
    issue(1'b0, 1'b0, 4'hf, 1'b1, 4'b0011, 1'b0, 1);
    step();
    chk("add_valid_drop", 32'(out_valid), 32'h0);

    // beq wins over multiply func
    issue(1'b1, 1'b1, 4'b1000, 1'b1, 4'b0010, 1'b0, 1);
    chk("beq_busy0", 32'(busy), 32'h0);
    step();
    chk("beq_busy1", 32'(busy), 32'h0);

    // Multiply: busy cycles 1..3, result cycle 4, back-to-back issue in cycle 4
    issue(1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 4);
    for (int k = 1; k <= 3; k++) begin
      chk("mul_busy", 32'(busy), 32'h1);
      chk("mul_ready", 32'(in_ready), 32'h0);
      step();
    end
    chk("mul_ready_done", 32'(in_ready), 32'h1);
    chk("mul_busy_done", 32'(busy), 32'h0);
    issue(1'b1, 1'b0, 4'b0101, 1'b1, 4'b0101, 1'b0, 1);
    step();

    // Divide aborted by flush in cycle 3; input in the flush cycle dropped
    issue(1'b1, 1'b0, 4'b1001, 1'b0, 4'h0, 1'b0, 0);
    step();
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    rtype    = 1'b0;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    chk("flush_multi", 32'(out_multi), 32'h0);
    chk("flush_op_hold", 32'(out_op), 32'b1001);
    for (int k = 4; k <= 10; k++) begin
      chk("flush_no_valid", 32'(out_valid), 32'h0);
      step();
    end

    // Flush in IDLE drops the presented input
    in_valid = 1'b1;
    rtype    = 1'b0;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_valid", 32'(out_valid), 32'h0);
    chk("idle_flush_op", 32'(out_op), 32'b1001);

    // Divide aborted by reset in cycle 3
    issue(1'b1, 1'b0, 4'b1001, 1'b0, 4'h0, 1'b0, 0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rabort_op", 32'(out_op), 32'h0);
    chk("rabort_valid", 32'(out_valid), 32'h0);
    chk("rabort_multi", 32'(out_multi), 32'h0);
    chk("rabort_busy", 32'(busy), 32'h0);
    chk("rabort_ready", 32'(in_ready), 32'h1);
    chk("rabort_ready2", 32'(in_ready2), 32'h1);
    step();

    // Stream of single-cycle ops, one per cycle
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      in_valid = 1'b1;
      rtype    = 1'b1;
      beq      = 1'b0;
      func     = 4'(i);
      e.op     = 4'(i);
      e.multi  = 1'b0;
      e.cyc    = cyc + 1;
      sbq.push_back(e);
      step();
    end
    in_valid = 1'b0;
    step();

    // Inputs held valid during BUSY are ignored
    issue(1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 4);
    in_valid = 1'b1;
    rtype    = 1'b1;
    beq      = 1'b0;
    func     = 4'b0101;
    for (int k = 1; k <= 3; k++) begin
      chk("busy_op_hold", 32'(out_op), 32'b1000);
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Wide func truncated to the low op bits
    in_valid2 = 1'b1;
    func2     = 6'b110111;
    step();
    in_valid2 = 1'b0;
    chk("wide_op", 32'(out_op2), 32'b0111);
    chk("wide_valid", 32'(out_valid2), 32'h1);
    chk("wide_busy", 32'(busy2), 32'h0);
    step();
    step();

    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
